// File: rtl/vending_controller.sv
// vending_controller: product selection, coin collection, dispense and
// change-return sequencing for a four-product vending machine.
module vending_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic       select_valid,
    input  logic [1:0] product_sel,
    input  logic       coin_valid,
    input  logic [1:0] coin_value,
    input  logic       cancel,
    input  logic       dispense_done,
    input  logic       change_ack,
    output logic [4:0] current_amount,
    output logic [4:0] product_price,
    output logic       enough_money,
    output logic       coin_reject,
    output logic       dispense_req,
    output logic [1:0] dispense_id,
    output logic       change_valid,
    output logic [4:0] change_amount,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COLLECT  = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic [4:0] r_amount;
    logic [4:0] r_price;
    logic [1:0] r_id;
    logic [4:0] r_change;
    logic       r_coin_reject;

    logic [4:0] w_amount_next;
    logic [4:0] w_price_next;
    logic [1:0] w_id_next;
    logic [4:0] w_change_next;
    logic       w_coin_reject_next;

    logic [4:0] w_coin_amt;
    logic [5:0] w_sum;
    logic [4:0] w_diff;
    logic       w_enough;

    // Fixed price table indexed by product number.
    function automatic logic [4:0] price_of(input logic [1:0] idx);
        case (idx)
            2'd0:    price_of = 5'd10;
            2'd1:    price_of = 5'd15;
            2'd2:    price_of = 5'd20;
            default: price_of = 5'd25;
        endcase
    endfunction

    // Coin code to credit value.
    function automatic logic [4:0] coin_of(input logic [1:0] code);
        case (code)
            2'b00:   coin_of = 5'd1;
            2'b01:   coin_of = 5'd2;
            2'b10:   coin_of = 5'd5;
            default: coin_of = 5'd10;
        endcase
    endfunction

    // Datapath terms shared by the next-state logic.
    always_comb begin
        w_coin_amt = coin_of(coin_value);
        // One extra bit so an addition past 31 is visible as a carry.
        w_sum      = {1'b0, r_amount} + {1'b0, w_coin_amt};
        // DISPENSE is only reached with credit >= price, so this never wraps.
        w_diff     = r_amount - r_price;
        w_enough   = (r_state == S_COLLECT) && (r_amount >= r_price);
    end

    // Next-state and next-register values; every coin is rejected unless
    // explicitly credited below.
    always_comb begin
        w_state_next       = r_state;
        w_amount_next      = r_amount;
        w_price_next       = r_price;
        w_id_next          = r_id;
        w_change_next      = r_change;
        w_coin_reject_next = coin_valid;

        case (r_state)
            S_IDLE: begin
                if (select_valid) begin
                    w_id_next     = product_sel;
                    w_price_next  = price_of(product_sel);
                    w_amount_next = '0;
                    w_state_next  = S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (cancel) begin
                    // Full refund of whatever has been inserted so far.
                    w_change_next = r_amount;
                    w_state_next  = (r_amount == '0) ? S_IDLE : S_CHANGE;
                end else if (w_enough) begin
                    w_state_next = S_DISPENSE;
                end else if (coin_valid && !w_sum[5]) begin
                    w_amount_next      = w_sum[4:0];
                    w_coin_reject_next = 1'b0;
                end
            end

            S_DISPENSE: begin
                if (dispense_done) begin
                    if (w_diff != '0) begin
                        w_change_next = w_diff;
                        w_state_next  = S_CHANGE;
                    end else begin
                        w_amount_next = '0;
                        w_state_next  = S_IDLE;
                    end
                end
            end

            S_CHANGE: begin
                if (change_ack) begin
                    w_amount_next = '0;
                    w_change_next = '0;
                    w_state_next  = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_amount      <= '0;
            r_price       <= '0;
            r_id          <= '0;
            r_change      <= '0;
            r_coin_reject <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_amount      <= w_amount_next;
            r_price       <= w_price_next;
            r_id          <= w_id_next;
            r_change      <= w_change_next;
            r_coin_reject <= w_coin_reject_next;
        end
    end

    assign current_amount = r_amount;
    assign product_price  = r_price;
    assign enough_money   = w_enough;
    assign coin_reject    = r_coin_reject;
    assign dispense_req   = (r_state == S_DISPENSE);
    assign dispense_id    = r_id;
    assign change_valid   = (r_state == S_CHANGE);
    assign change_amount  = r_change;
    assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_vending_controller.sv
// Directed testbench for vending_controller.
module tb_vending_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       select_valid = 1'b0;
    logic [1:0] product_sel = '0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_value = '0;
    logic       cancel = 1'b0;
    logic       dispense_done = 1'b0;
    logic       change_ack = 1'b0;
    logic [4:0] current_amount;
    logic [4:0] product_price;
    logic       enough_money;
    logic       coin_reject;
    logic       dispense_req;
    logic [1:0] dispense_id;
    logic       change_valid;
    logic [4:0] change_amount;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    vending_controller dut (
        .clk(clk), .rst(rst),
        .select_valid(select_valid), .product_sel(product_sel),
        .coin_valid(coin_valid), .coin_value(coin_value),
        .cancel(cancel), .dispense_done(dispense_done), .change_ack(change_ack),
        .current_amount(current_amount), .product_price(product_price),
        .enough_money(enough_money), .coin_reject(coin_reject),
        .dispense_req(dispense_req), .dispense_id(dispense_id),
        .change_valid(change_valid), .change_amount(change_amount),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sel(input logic [1:0] p);
        select_valid = 1'b1; product_sel = p;
        step();
        select_valid = 1'b0;
    endtask

    task automatic coin(input logic [1:0] c);
        coin_valid = 1'b1; coin_value = c;
        step();
        coin_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; select_valid = 1'b1; product_sel = 2'd2; coin_valid = 1'b1; coin_value = 2'b11;
        step();
        rst = 1'b0; select_valid = 1'b0; coin_valid = 1'b0;
        n_checks++; if (current_amount !== 5'd0) begin n_fail++; $display("FAIL rst_amount: got %0d exp 0", current_amount); end
        n_checks++; if (product_price !== 5'd0) begin n_fail++; $display("FAIL rst_price: got %0d exp 0", product_price); end
        n_checks++; if (dispense_req !== 1'b0 || dispense_id !== 2'd0) begin n_fail++; $display("FAIL rst_dispense: got req=%0d id=%0d exp 0/0", dispense_req, dispense_id); end
        n_checks++; if (change_valid !== 1'b0 || change_amount !== 5'd0) begin n_fail++; $display("FAIL rst_change: got v=%0d amt=%0d exp 0/0", change_valid, change_amount); end
        n_checks++; if (coin_reject !== 1'b0) begin n_fail++; $display("FAIL rst_coin_reject: got %0d exp 0", coin_reject); end
        n_checks++; if (busy !== 1'b0 || enough_money !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got busy=%0d enough=%0d exp 0/0", busy, enough_money); end
        step();
        n_checks++; if (busy !== 1'b0 || coin_reject !== 1'b0) begin n_fail++; $display("FAIL rst_discard: got busy=%0d rej=%0d exp 0/0", busy, coin_reject); end
    endtask

    task automatic test_exact_price();
        sel(2'd1);
        n_checks++; if (product_price !== 5'd15 || busy !== 1'b1) begin n_fail++; $display("FAIL exact_select: got price=%0d busy=%0d exp 15/1", product_price, busy); end
        coin(2'b11);
        n_checks++; if (current_amount !== 5'd10 || enough_money !== 1'b0) begin n_fail++; $display("FAIL exact_coin10: got amt=%0d enough=%0d exp 10/0", current_amount, enough_money); end
        coin(2'b10);
        n_checks++; if (current_amount !== 5'd15 || enough_money !== 1'b1 || coin_reject !== 1'b0) begin n_fail++; $display("FAIL exact_coin5: got amt=%0d enough=%0d rej=%0d exp 15/1/0", current_amount, enough_money, coin_reject); end
        step();
        n_checks++; if (dispense_req !== 1'b1 || dispense_id !== 2'd1 || enough_money !== 1'b0) begin n_fail++; $display("FAIL exact_dispense: got req=%0d id=%0d enough=%0d exp 1/1/0", dispense_req, dispense_id, enough_money); end
        step();
        n_checks++; if (dispense_req !== 1'b1) begin n_fail++; $display("FAIL exact_hold: got req=%0d exp 1", dispense_req); end
        dispense_done = 1'b1; step(); dispense_done = 1'b0;
        n_checks++; if (dispense_req !== 1'b0 || busy !== 1'b0 || change_valid !== 1'b0) begin n_fail++; $display("FAIL exact_done: got req=%0d busy=%0d cv=%0d exp 0/0/0", dispense_req, busy, change_valid); end
    endtask

    task automatic test_change();
        sel(2'd0);
        sel(2'd3);
        n_checks++; if (product_price !== 5'd10) begin n_fail++; $display("FAIL chg_select_ignored: got price=%0d exp 10", product_price); end
        coin(2'b10);
        coin(2'b11);
        n_checks++; if (current_amount !== 5'd15 || enough_money !== 1'b1) begin n_fail++; $display("FAIL chg_credit: got amt=%0d enough=%0d exp 15/1", current_amount, enough_money); end
        step();
        n_checks++; if (dispense_req !== 1'b1 || dispense_id !== 2'd0) begin n_fail++; $display("FAIL chg_dispense: got req=%0d id=%0d exp 1/0", dispense_req, dispense_id); end
        change_ack = 1'b1; step(); change_ack = 1'b0;
        n_checks++; if (dispense_req !== 1'b1) begin n_fail++; $display("FAIL chg_ack_ignored: got req=%0d exp 1", dispense_req); end
        dispense_done = 1'b1; step(); dispense_done = 1'b0;
        n_checks++; if (change_valid !== 1'b1 || change_amount !== 5'd5 || dispense_req !== 1'b0) begin n_fail++; $display("FAIL chg_enter: got cv=%0d amt=%0d req=%0d exp 1/5/0", change_valid, change_amount, dispense_req); end
        step();
        n_checks++; if (change_valid !== 1'b1 || change_amount !== 5'd5) begin n_fail++; $display("FAIL chg_hold: got cv=%0d amt=%0d exp 1/5", change_valid, change_amount); end
        change_ack = 1'b1; step(); change_ack = 1'b0;
        n_checks++; if (busy !== 1'b0 || current_amount !== 5'd0 || change_valid !== 1'b0 || change_amount !== 5'd0) begin n_fail++; $display("FAIL chg_ack: got busy=%0d amt=%0d cv=%0d ca=%0d exp 0/0/0/0", busy, current_amount, change_valid, change_amount); end
    endtask

    task automatic test_cancel();
        sel(2'd3);
        coin(2'b11);
        coin(2'b10);
        n_checks++; if (current_amount !== 5'd15 || enough_money !== 1'b0) begin n_fail++; $display("FAIL cxl_credit: got amt=%0d enough=%0d exp 15/0", current_amount, enough_money); end
        cancel = 1'b1; coin_valid = 1'b1; coin_value = 2'b00;
        step();
        cancel = 1'b0; coin_valid = 1'b0;
        n_checks++; if (change_valid !== 1'b1 || change_amount !== 5'd15 || dispense_req !== 1'b0) begin n_fail++; $display("FAIL cxl_change: got cv=%0d amt=%0d req=%0d exp 1/15/0", change_valid, change_amount, dispense_req); end
        n_checks++; if (coin_reject !== 1'b1 || current_amount !== 5'd15) begin n_fail++; $display("FAIL cxl_coin_reject: got rej=%0d amt=%0d exp 1/15", coin_reject, current_amount); end
        change_ack = 1'b1; step(); change_ack = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cxl_idle: got busy=%0d exp 0", busy); end
    endtask

    task automatic test_reject();
        coin(2'b11);
        n_checks++; if (coin_reject !== 1'b1 || current_amount !== 5'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_coin: got rej=%0d amt=%0d busy=%0d exp 1/0/0", coin_reject, current_amount, busy); end
        step();
        n_checks++; if (coin_reject !== 1'b0) begin n_fail++; $display("FAIL idle_pulse: got rej=%0d exp 0", coin_reject); end
        // 10+10+2+2 = 24, then a 10 would make 34 (> 31)
        sel(2'd3);
        coin(2'b11); coin(2'b11); coin(2'b01); coin(2'b01);
        n_checks++; if (current_amount !== 5'd24 || coin_reject !== 1'b0) begin n_fail++; $display("FAIL ovf_pre: got amt=%0d rej=%0d exp 24/0", current_amount, coin_reject); end
        coin(2'b11);
        n_checks++; if (coin_reject !== 1'b1 || current_amount !== 5'd24) begin n_fail++; $display("FAIL ovf_reject: got rej=%0d amt=%0d exp 1/24", coin_reject, current_amount); end
        coin(2'b00);
        n_checks++; if (current_amount !== 5'd25 || enough_money !== 1'b1) begin n_fail++; $display("FAIL ovf_final: got amt=%0d enough=%0d exp 25/1", current_amount, enough_money); end
        step();
        n_checks++; if (dispense_req !== 1'b1 || dispense_id !== 2'd3) begin n_fail++; $display("FAIL ovf_dispense: got req=%0d id=%0d exp 1/3", dispense_req, dispense_id); end
        dispense_done = 1'b1; step(); dispense_done = 1'b0;
        n_checks++; if (busy !== 1'b0 || change_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_done: got busy=%0d cv=%0d exp 0/0", busy, change_valid); end
        // Credit 30 against price 25; a 2 offered while enough_money=1 is refused.
        sel(2'd3);
        coin(2'b11); coin(2'b11);
        n_checks++; if (current_amount !== 5'd20) begin n_fail++; $display("FAIL c30_pre: got amt=%0d exp 20", current_amount); end
        coin(2'b11);
        n_checks++; if (current_amount !== 5'd30 || enough_money !== 1'b1) begin n_fail++; $display("FAIL c30_credit: got amt=%0d enough=%0d exp 30/1", current_amount, enough_money); end
        coin(2'b01);
        n_checks++; if (coin_reject !== 1'b1 || current_amount !== 5'd30 || dispense_req !== 1'b1) begin n_fail++; $display("FAIL c30_reject: got rej=%0d amt=%0d req=%0d exp 1/30/1", coin_reject, current_amount, dispense_req); end
        dispense_done = 1'b1; step(); dispense_done = 1'b0;
        n_checks++; if (change_valid !== 1'b1 || change_amount !== 5'd5) begin n_fail++; $display("FAIL c30_change: got cv=%0d amt=%0d exp 1/5", change_valid, change_amount); end
        change_ack = 1'b1; step(); change_ack = 1'b0;
        n_checks++; if (busy !== 1'b0 || current_amount !== 5'd0) begin n_fail++; $display("FAIL c30_idle: got busy=%0d amt=%0d exp 0/0", busy, current_amount); end
    endtask

    task automatic test_reset_dispense();
        sel(2'd0);
        coin(2'b11);
        step();
        n_checks++; if (dispense_req !== 1'b1) begin n_fail++; $display("FAIL rstd_pre: got req=%0d exp 1", dispense_req); end
        rst = 1'b1; cancel = 1'b1; step(); rst = 1'b0; cancel = 1'b0;
        n_checks++; if (dispense_req !== 1'b0 || dispense_id !== 2'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstd_dispense: got req=%0d id=%0d busy=%0d exp 0/0/0", dispense_req, dispense_id, busy); end
        n_checks++; if (current_amount !== 5'd0 || product_price !== 5'd0 || change_valid !== 1'b0 || change_amount !== 5'd0 || coin_reject !== 1'b0) begin n_fail++; $display("FAIL rstd_regs: got amt=%0d price=%0d cv=%0d ca=%0d rej=%0d exp all 0", current_amount, product_price, change_valid, change_amount, coin_reject); end
    endtask

    task automatic test_cancel_enough();
        sel(2'd2);
        coin(2'b11); coin(2'b11);
        n_checks++; if (enough_money !== 1'b1 || current_amount !== 5'd20) begin n_fail++; $display("FAIL cxe_pre: got enough=%0d amt=%0d exp 1/20", enough_money, current_amount); end
        cancel = 1'b1; step(); cancel = 1'b0;
        n_checks++; if (change_valid !== 1'b1 || change_amount !== 5'd20 || dispense_req !== 1'b0) begin n_fail++; $display("FAIL cxe_change: got cv=%0d amt=%0d req=%0d exp 1/20/0", change_valid, change_amount, dispense_req); end
        step();
        n_checks++; if (dispense_req !== 1'b0 || change_valid !== 1'b1) begin n_fail++; $display("FAIL cxe_hold: got req=%0d cv=%0d exp 0/1", dispense_req, change_valid); end
        change_ack = 1'b1; step(); change_ack = 1'b0;
        // Cancel with no credit returns straight to IDLE.
        sel(2'd1);
        cancel = 1'b1; step(); cancel = 1'b0;
        n_checks++; if (busy !== 1'b0 || change_valid !== 1'b0) begin n_fail++; $display("FAIL cxe_zero: got busy=%0d cv=%0d exp 0/0", busy, change_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        step();
        test_reset();
        test_exact_price();
        test_change();
        test_cancel();
        test_reject();
        test_reset_dispense();
        test_cancel_enough();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
